snax_reshuffler_input_packer: RTL and testbench
===============================================

Name: snax_reshuffler_input_packer

Overview:
Upstream feeder for the data reshuffler. It packs narrow words from a streamer read port into full-width beats on the reshuffler's 512-bit input stream. A CSR-programmed word count defines one job. The last beat of a job is zero-padded. The block reports a busy flag and a busy-cycle performance counter.

Parameters:
InWidth, 64, width of one input word in bits
OutWidth, 512, width of one output beat; must be an integer multiple of InWidth
CntWidth, 32, width of the job word counter and the performance counter
(derived) Ratio = OutWidth/InWidth (default 8); LaneIdxW = $clog2(Ratio)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
in_data_i  in  InWidth  input word from streamer
in_valid_i  in  1  input word valid
in_ready_o  out  1  input word accepted
out_data_o  out  OutWidth  packed beat to reshuffler
out_valid_o  out  1  beat valid
out_ready_i  in  1  reshuffler accepts beat
cfg_words_i  in  CntWidth  number of input words in the job
cfg_valid_i  in  1  job configuration valid
cfg_ready_o  out  1  configuration accepted
busy_o  out  1  job in progress
perf_cnt_o  out  CntWidth  busy cycles of last/current job
stall_cnt_o  out  CntWidth  output stall cycles (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, perf_cnt_o=0, stall_cnt_o=0, cfg_ready_o=1. Internal state: IDLE, lane index 0, remaining-word count 0.
- Reset mid-job: all state is discarded immediately (asynchronous). No partial beat is emitted after reset release.

FSM, three states:
- IDLE:
  - cfg_ready_o=1, busy_o=0, in_ready_o=0.
  - On cfg_valid_i && cfg_words_i!=0: latch remaining=cfg_words_i, clear perf_cnt_o and stall_cnt_o, go to PACK.
  - On cfg_valid_i && cfg_words_i==0: the handshake completes and the block stays in IDLE. Counters are not cleared.
- PACK:
  - cfg_ready_o=0, busy_o=1.
  - An accepted word is written to lanes [lane*InWidth +: InWidth] of the pack buffer. lane increments and remaining decrements.
  - closing = (lane==Ratio-1) || (remaining==1).
  - in_ready_o = !closing || !out_valid_o || out_ready_i. This is a combinational path from out_ready_i to in_ready_o; the path is accepted.
  - On an accepted closing word:
    - The completed beat (pack buffer plus this word) loads the output register and out_valid_o=1 on the next cycle.
    - Lanes above the closing lane are zero.
    - The pack buffer clears and lane resets to 0.
  - If the closing word is also the last word of the job (remaining==1), go to DRAIN.
- DRAIN:
  - in_ready_o=0, busy_o=1.
  - When the final beat handshakes (out_valid_o && out_ready_i), go to IDLE. busy_o falls on the next cycle.

Output handshake:
- out_valid_o stays asserted until out_ready_i.
- out_data_o is stable while out_valid_o && !out_ready_i.
- When no new beat is loaded, the handshake clears out_valid_o.
- Same-cycle drain and load of the output register is allowed.
- Throughput: 1 input word per cycle sustained when out_ready_i=1. First beat latency is Ratio cycles after the first word, plus 1 register cycle.

Counters:
- perf_cnt_o increments every cycle busy_o=1 and saturates at all-ones.
- It holds its value in IDLE until the next accepted nonzero configuration.

Ignored signals:
- in_valid_i is ignored outside PACK.
- cfg_valid_i is ignored while busy.

Optional Feature:
Macro SNAX_RESHUFFLER_PACKER_STALL_CNT_EN.
- Defined: stall_cnt_o counts cycles with out_valid_o && !out_ready_i during a job. It saturates and is cleared on an accepted nonzero configuration.
- Undefined: stall_cnt_o is tied to 0 and its counter logic is absent. The port list is unchanged.

Decomposition:
- Package snax_reshuffler_packer_pkg holds:
  - the state enum typedef (IDLE, PACK, DRAIN);
  - default width constants (InWidth, OutWidth, CntWidth);
  - a saturating-increment function shared by both counters.
- One natural sub-module: snax_packer_out_reg, a single-entry valid/ready output register with a load port.
- FSM and lane logic stay in the top module.

Test Plan:
- Full job, no backpressure: cfg_words=16, words 0x1..0x10 back-to-back, out_ready=1.
  - Expect two beats: beat0 lanes 0..7 = 0x1..0x8, beat1 = 0x9..0x10.
  - in_ready is never low; busy falls 1 cycle after beat1 handshake.
- Partial last beat: cfg_words=11.
  - Expect beat1 lanes 0..2 = words 9..11 and lanes 3..7 = 0.
  - Expect exactly 2 beats.
- Backpressure: cfg_words=24 with out_ready held low for 10 cycles after beat0.
  - in_ready drops only on the closing word of beat1.
  - out_data is stable while stalled; no word is lost or duplicated.
  - With the macro defined, stall_cnt=10.
- Zero-length and busy config:
  - cfg_words=0 completes the handshake; busy stays 0 and no beat is emitted.
  - A cfg_valid pulse mid-job sees cfg_ready=0 and the job is unaffected.
- Reset mid-job: assert rst_ni low after 5 of 8 words.
  - All outputs return to reset values asynchronously.
  - A new cfg_words=8 job yields one clean beat with no stale lanes.
- Perf counter: cfg_words=8, one word every 2 cycles.
  - perf_cnt equals the busy-high cycle count and holds in IDLE.
  - It clears on the next configuration.

Source files
------------

// File: rtl/snax_reshuffler_packer_pkg.sv
// Shared state type, default widths and the saturating counter helper for the
// reshuffler input packer.
package snax_reshuffler_packer_pkg;

    localparam int unsigned DefaultInWidth  = 64;
    localparam int unsigned DefaultOutWidth = 512;
    localparam int unsigned DefaultCntWidth = 32;
    localparam int unsigned MaxCntWidth     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } packer_state_e;

    // The ceiling follows the caller's counter width, so narrow counters stick at their own all-ones.
    function automatic logic [MaxCntWidth-1:0] sat_inc(input logic [MaxCntWidth-1:0] value,
                                                       input int unsigned           width);
        logic [MaxCntWidth-1:0] ceiling;
        ceiling = (width >= MaxCntWidth) ? '1
                                         : ((MaxCntWidth'(1) << width) - MaxCntWidth'(1));
        return (value >= ceiling) ? value : value + MaxCntWidth'(1);
    endfunction

endpackage

// File: rtl/snax_packer_out_reg.sv
// Single-entry valid/ready output register; a load may coincide with the
// draining handshake of the previous beat.
module snax_packer_out_reg #(
    parameter int unsigned Width = 512
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_data_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (load_i) begin
            data_o  <= load_data_i;
            valid_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/snax_reshuffler_input_packer.sv
// Packs InWidth words into zero-padded OutWidth beats for one CSR-defined job.
// Optional stall counter: define SNAX_RESHUFFLER_PACKER_STALL_CNT_EN.
module snax_reshuffler_input_packer
    import snax_reshuffler_packer_pkg::*;
#(
    parameter int unsigned InWidth  = DefaultInWidth,
    parameter int unsigned OutWidth = DefaultOutWidth,
    parameter int unsigned CntWidth = DefaultCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [InWidth-1:0]  in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [OutWidth-1:0] out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    input  logic [CntWidth-1:0] cfg_words_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] perf_cnt_o,
    output logic [CntWidth-1:0] stall_cnt_o
);

    localparam int unsigned Ratio    = OutWidth / InWidth;
    localparam int unsigned LaneIdxW = (Ratio > 1) ? $clog2(Ratio) : 1;

    packer_state_e       state_q, state_d;
    logic [LaneIdxW-1:0] lane_q;
    logic [CntWidth-1:0] remaining_q;
    logic [OutWidth-1:0] pack_buf_q;
    logic [OutWidth-1:0] beat_data;
    logic                closing;
    logic                in_accept;
    logic                cfg_start;
    logic                load_beat;

    assign closing     = (lane_q == LaneIdxW'(Ratio - 1)) || (remaining_q == CntWidth'(1));
    // A closing word may only enter when the output register can take the beat this cycle.
    assign in_ready_o  = (state_q == PACK) && (!closing || !out_valid_o || out_ready_i);
    assign cfg_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign in_accept   = in_valid_i && in_ready_o;
    assign cfg_start   = cfg_valid_i && cfg_ready_o && (cfg_words_i != '0);
    assign load_beat   = in_accept && closing;

    always_comb begin
        beat_data = pack_buf_q;
        beat_data[lane_q*InWidth +: InWidth] = in_data_i;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cfg_start) state_d = PACK;
            PACK:    if (load_beat && (remaining_q == CntWidth'(1))) state_d = DRAIN;
            DRAIN:   if (out_valid_o && out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The buffer is cleared on every closing word so a short last beat sees zeros above its top lane.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q      <= '0;
            remaining_q <= '0;
            pack_buf_q  <= '0;
        end else begin
            if (cfg_start) begin
                remaining_q <= cfg_words_i;
            end else if (in_accept) begin
                remaining_q <= remaining_q - CntWidth'(1);
            end
            if (in_accept) begin
                if (closing) begin
                    lane_q     <= '0;
                    pack_buf_q <= '0;
                end else begin
                    lane_q     <= lane_q + LaneIdxW'(1);
                    pack_buf_q <= beat_data;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_o <= '0;
        end else if (cfg_start) begin
            perf_cnt_o <= '0;
        end else if (busy_o) begin
            perf_cnt_o <= CntWidth'(sat_inc(MaxCntWidth'(perf_cnt_o), CntWidth));
        end
    end

`ifdef SNAX_RESHUFFLER_PACKER_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (cfg_start) begin
            stall_cnt_o <= '0;
        end else if (busy_o && out_valid_o && !out_ready_i) begin
            stall_cnt_o <= CntWidth'(sat_inc(MaxCntWidth'(stall_cnt_o), CntWidth));
        end
    end
`else
    assign stall_cnt_o = '0;
`endif

    snax_packer_out_reg #(
        .Width (OutWidth)
    ) i_out_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load_beat),
        .load_data_i (beat_data),
        .data_o      (out_data_o),
        .valid_o     (out_valid_o),
        .ready_i     (out_ready_i)
    );

endmodule

// File: tb/tb_snax_reshuffler_input_packer.sv
// Bench for the reshuffler input packer: table of jobs checked against a
// beat-level model, plus zero-length, reset and mid-job config sequences.
module tb_snax_reshuffler_input_packer;

    typedef struct {
        int n;
        int gap_mode;
        int ready_mode;
        bit rand_data;
        bit mid_cfg;
        int exp_beats;
        int exp_perf;
        int exp_stall;
        int exp_drops;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  cfg_words;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         busy;
    logic [31:0]  perf_cnt;
    logic [31:0]  stall_cnt;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int last_perf = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    snax_reshuffler_input_packer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .cfg_words_i (cfg_words),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .busy_o      (busy),
        .perf_cnt_o  (perf_cnt),
        .stall_cnt_o (stall_cnt)
    );

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    function automatic bit is_closing(input int idx, input int n);
        return (idx % 8 == 7) || (idx == n - 1);
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_perf"}, perf_cnt, 0);
        checkOutput({tag, "_stall"}, stall_cnt, 0);
        checkOutput({tag, "_cfg_ready"}, cfg_ready, 1);
    endtask

    // Runs one job: configure, feed words, collect beats, compare to the model.
    task automatic applyStimulus(input vec_t v);
        logic [63:0]  words[$];
        logic [511:0] exp_q[$];
        logic [511:0] got_q[$];
        logic [511:0] beat;
        logic [511:0] held_data;
        int sent = 0, c = 0, stall_cycles = 0, drops = 0, bad_drops = 0, instab = 0;
        int stall_left = -1, want_beats, want_perf;
        bit done = 0, held = 0, word_hs, fin;

        for (int k = 0; k < v.n; k++)
            words.push_back(v.rand_data ? {$urandom(), $urandom()} : 64'(k + 1));
        for (int b = 0; b * 8 < v.n; b++) begin
            beat = '0;
            for (int j = 0; j < 8; j++)
                if (b * 8 + j < v.n) beat[j*64 +: 64] = words[b*8 + j];
            exp_q.push_back(beat);
        end
        want_beats = (v.exp_beats >= 0) ? v.exp_beats : exp_q.size();

        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_words = 32'(v.n);
        #1;
        checkOutput("cfg_ready_idle", cfg_ready, 1);
        @(posedge clk);

        while (!done && c < 2000) begin
            @(negedge clk);
            cfg_valid = (v.mid_cfg && c == 3);
            cfg_words = 32'd5;
            case (v.ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (stall_left < 0 && out_valid) stall_left = 10;
                    out_ready = !(stall_left > 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase
            in_valid = (sent < v.n) && ((v.gap_mode == 0) || (v.gap_mode == 1 && c % 2 == 0) ||
                                        (v.gap_mode == 2 && $urandom_range(0, 1) == 1));
            in_data  = in_valid ? words[sent] : {$urandom(), $urandom()};
            #1;
            if (c == 0) checkOutput("perf_cleared", perf_cnt, 0);
            if (v.mid_cfg && c == 3) checkOutput("cfg_ready_busy", cfg_ready, 0);
            if (held && out_data !== held_data) instab++;
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (held) stall_cycles++;
            if (in_valid && !in_ready) begin
                drops++;
                if (!(out_valid && !out_ready) || !is_closing(sent, v.n)) bad_drops++;
            end
            word_hs = in_valid && in_ready;
            fin = 0;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                fin = (got_q.size() >= want_beats);
                if (fin) checkOutput("busy_in_drain", busy, 1);
            end
            @(posedge clk);
            if (word_hs) sent++;
            c++;
            done = fin;
        end
        in_valid  = 1'b0;
        cfg_valid = 1'b0;

        checkOutput("job_done", done, 1);
        checkOutput("words_sent", sent, v.n);
        checkOutput("beat_count", got_q.size(), exp_q.size());
        for (int b = 0; b < got_q.size() && b < exp_q.size(); b++)
            checkOutput($sformatf("beat%0d", b), got_q[b], exp_q[b]);
        checkOutput("out_stable", instab, 0);
        checkOutput("drop_rule", bad_drops, 0);
        if (v.exp_drops >= 0) checkOutput("drop_count", drops, v.exp_drops);

        want_perf = (v.exp_perf >= 0) ? v.exp_perf : c;
        @(negedge clk);
        #1;
        checkOutput("busy_fell", busy, 0);
        checkOutput("no_extra_beat", out_valid, 0);
        checkOutput("perf_cnt", perf_cnt, want_perf);
`ifdef SNAX_RESHUFFLER_PACKER_STALL_CNT_EN
        checkOutput("stall_cnt", stall_cnt, (v.exp_stall >= 0) ? v.exp_stall : stall_cycles);
`else
        checkOutput("stall_cnt_tied", stall_cnt, 0);
`endif
        repeat (3) @(negedge clk);
        checkOutput("perf_hold", perf_cnt, want_perf);
        last_perf = want_perf;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // n, gap, ready, rand, midcfg, beats, perf, stall, drops
        vecs[0] = '{16, 0, 0, 0, 0, 2, 17, 0, 0};
        vecs[1] = '{11, 0, 0, 0, 0, 2, 12, 0, 0};
        vecs[2] = '{24, 0, 2, 0, 0, 3, 28, 10, 3};
        vecs[3] = '{8, 1, 0, 0, 1, 1, 16, 0, 0};
        for (int i = 4; i < 10; i++)
            vecs[i] = '{int'($urandom_range(1, 40)), 2, 1, 1, 0, -1, -1, -1, -1};

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cfg_words = '0;
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Zero-length job completes its handshake without starting work.
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_words = '0;
        #1;
        checkOutput("zero_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("zero_busy", busy, 0);
            checkOutput("zero_no_beat", out_valid, 0);
        end
        checkOutput("zero_perf_kept", perf_cnt, last_perf);

        // Reset after 5 of 8 words, then a clean job.
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_words = 32'd8;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 64'hdead_0000 + 64'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus('{8, 0, 0, 1, 0, 1, 9, 0, 0});

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
